// File: rtl/mem_bus_ctrl.sv
// Bridge from the picorv32 native memory bus to RAM/ROM blocks and an I/O port.
// Optional macro ROM_WP_EN write-protects the ROM region (writes blocked, bus_err raised).
module mem_bus_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_WORD       = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic [13:0] bus_adr,
    output logic [31:0] bus_di,
    output logic [3:0]  bus_wren,
    output logic        ram_cs,
    output logic        rom_cs,
    input  logic [31:0] ram_do,
    input  logic [31:0] rom_do,
    output logic        io_valid,
    output logic [15:0] io_addr,
    output logic [31:0] io_wdata,
    output logic [3:0]  io_wstrb,
    input  logic        io_ready,
    input  logic [31:0] io_rdata,
    output logic        bus_err
);

    localparam logic [1:0]  ST_IDLE    = 2'd0;
    localparam logic [1:0]  ST_IO_WAIT = 2'd1;
    localparam logic [1:0]  ST_RESP    = 2'd2;

    localparam logic [1:0]  RG_RAM = 2'b00;
    localparam logic [1:0]  RG_IO  = 2'b01;
    localparam logic [1:0]  RG_ROM = 2'b10;
    localparam logic [1:0]  RG_ERR = 2'b11;

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [1:0]  state_r;
    logic [1:0]  region_r;
    logic [15:0] cnt_r;
    logic [31:0] rdata_r;
    logic        ready_r;
    logic        err_r;

    logic [1:0]  region_s;
    logic        req_s;
    logic        rom_wp_s;
    logic        unused_s;

    assign region_s = mem_addr[17:16];
    assign unused_s = ^mem_addr[31:18];
    assign req_s    = !rst && (state_r == ST_IDLE) && mem_valid;

    // Flags a ROM write that must be blocked when write protection is built in
    always_comb begin
        rom_wp_s = 1'b0;
`ifdef ROM_WP_EN
        if ((region_s == RG_ROM) && (mem_wstrb != 4'b0000)) begin
            rom_wp_s = 1'b1;
        end else begin
            rom_wp_s = 1'b0;
        end
`else
        rom_wp_s = 1'b0;
`endif
    end

    // Memory strobes are combinational so the synchronous RAM sees the request this cycle
    assign ram_cs   = req_s && (region_s == RG_RAM);
    assign rom_cs   = req_s && (region_s == RG_ROM) && !rom_wp_s;
    assign bus_wren = (ram_cs || rom_cs) ? mem_wstrb : 4'b0000;
    assign bus_adr  = mem_addr[15:2];
    assign bus_di   = mem_wdata;

    assign io_valid = (state_r == ST_IO_WAIT);
    assign io_addr  = mem_addr[15:0];
    assign io_wdata = mem_wdata;
    assign io_wstrb = mem_wstrb;

    assign mem_ready = ready_r;
    assign bus_err   = err_r;

    // Read data source follows the region latched at request time
    always_comb begin
        mem_rdata = rdata_r;
        case (region_r)
            RG_RAM:  mem_rdata = ram_do;
            RG_ROM:  mem_rdata = rom_do;
            default: mem_rdata = rdata_r;
        endcase
    end

    // Transaction FSM, timeout counter and response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            region_r <= RG_ERR;     // selects rdata_r so mem_rdata reads 0 out of reset
            cnt_r    <= 16'd0;
            rdata_r  <= 32'd0;
            ready_r  <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    ready_r <= 1'b0;
                    err_r   <= 1'b0;
                    if (mem_valid) begin
                        region_r <= region_s;
                        case (region_s)
                            RG_RAM, RG_ROM: begin
                                state_r <= ST_RESP;
                                ready_r <= 1'b1;
                                err_r   <= rom_wp_s;
                            end
                            RG_IO: begin
                                state_r <= ST_IO_WAIT;
                                cnt_r   <= 16'd0;
                            end
                            default: begin
                                state_r <= ST_RESP;
                                rdata_r <= ERR_WORD;
                                ready_r <= 1'b1;
                                err_r   <= 1'b1;
                            end
                        endcase
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_IO_WAIT: begin
                    if (io_ready) begin
                        state_r <= ST_RESP;
                        rdata_r <= io_rdata;
                        ready_r <= 1'b1;
                        err_r   <= 1'b0;
                    end else if (cnt_r == CNT_LAST) begin
                        state_r <= ST_RESP;
                        rdata_r <= ERR_WORD;
                        ready_r <= 1'b1;
                        err_r   <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + 16'd1;
                    end
                end
                ST_RESP: begin
                    state_r <= ST_IDLE;
                    ready_r <= 1'b0;
                    err_r   <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    ready_r <= 1'b0;
                    err_r   <= 1'b0;
                end
            endcase
        end
    end

endmodule
